data_mem_arbiter: RTL
=====================

# data_mem_arbiter

- Two-port round-robin arbiter that shares the single-ported `Data_Memory` (16-bit words, 8 entries, `addr[2:0]` decoded) between requester 0 (CPU load/store stage) and requester 1 (DMA/debug port).
- Sits between both requesters and the memory's `mem_access_addr` / `mem_write_data` / `mem_write_en` / `mem_read` / `mem_read_data` pins.
- Returns registered read data per port and bounds locked bursts so neither side starves.

## Interface
Parameters:
- `DATA_W`, 16, data width; matches memory word.
- `ADDR_W`, 16, address width; passed through unmodified.
- `LOCK_MAX`, 4, max consecutive locked grants while the other port is requesting (1..15).

Ports:
- `clk` input 1: single clock; all state updates on posedge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `req0`, `req1` input 1: access request; held until the access completes.
- `we0`, `we1` input 1: 1 = write, 0 = read; valid with `req`.
- `lock0`, `lock1` input 1: request to keep ownership after the current access.
- `addr0`, `addr1` input ADDR_W: access address.
- `wdata0`, `wdata1` input DATA_W: write data.
- `gnt0`, `gnt1` output 1: port owns the memory this cycle; decoded from state.
- `rvalid0`, `rvalid1` output 1: one-cycle pulse; `rdataN` is valid.
- `rdata0`, `rdata1` output DATA_W: registered read data, held until the next read on that port.
- `mem_access_addr` output ADDR_W: to memory.
- `mem_write_data` output DATA_W: to memory.
- `mem_write_en` output 1: to memory.
- `mem_read` output 1: to memory.
- `mem_read_data` input DATA_W: from memory; combinational read.

## Operation
FSM states: IDLE, OWN0, OWN1. Also held: `last` (last-served port), `lock_cnt` (4 bits).
- **IDLE**
  - Both `gnt` = 0; all memory outputs 0.
  - Any `req` moves to OWNx. If both request, the winner is the port not equal to `last`.
- **OWNx**
  - `gntx` = 1. Memory address and data are muxed from port x.
  - `mem_write_en` = `reqx & wex`.
  - `mem_read` = `reqx & ~wex`.
  - A cycle with `gntx & reqx` is one completed access. `last` <= x.
- **Next state from OWNx**, evaluated on each edge, in priority order:
  1. `reqx & lockx` and other port idle: stay; `lock_cnt` holds.
  2. `reqx & lockx` and other port requesting and `lock_cnt < LOCK_MAX-1`: stay; `lock_cnt` += 1.
  3. Other port requesting: go to OWN(other) with no idle bubble; `lock_cnt` <= 0.
  4. `reqx` still high: stay.
  5. Otherwise: go to IDLE; `lock_cnt` <= 0.
- **Forced handoff.** After `LOCK_MAX` consecutive locked accesses with the other port waiting, ownership transfers (rule 3) even if `lockx` = 1.
- **Dropped request.** `reqx` low while granted performs no access; memory enables are 0 that cycle.
- **Read return.** On an edge ending a read access: `rdatax` <= `mem_read_data`, and `rvalidx` = 1 for the next cycle. Writes produce no `rvalid`.
- **Address width.** Addresses pass through at full width. Aliasing above `addr[2:0]` is the memory's behaviour, not the arbiter's.
- **Reset** (any time, including mid-access):
  - State IDLE, `last` = 1 so port 0 wins the first tie, `lock_cnt` = 0.
  - All `gnt`, `rvalid` and `rdata` = 0.
  - `mem_write_en` and `mem_read` drop to 0 asynchronously, so no write occurs at a clock edge while `rst_n` = 0.

## Timing
- Cycle 0: `req` rises from IDLE. Cycle 1: `gnt` = 1 and the access occurs. Cycle 2: `rvalid` pulses for a read.
- Back-to-back on one port: one access per cycle while `req` is held and the other port is silent.
- Alternating contention (no lock): ownership alternates every cycle, giving each port 50 % throughput.
- Simultaneous requests from IDLE: the non-`last` port is granted. The loser's `gnt` rises one cycle after the winner's final access.
- Write data lands in memory at the edge ending the grant cycle. A read of the same address in the following cycle returns the new value.
- Memory outputs are combinational from the state register plus the owning port's inputs. There is no combinational path from `mem_read_data` to anything except the `rdata` registers.

## Structure
- Package `mem_arb_pkg`:
  - State encoding: IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2.
  - Port-index constants.
  - Default `DATA_W` / `ADDR_W`.
- Optional sub-module `mem_arb_port_mux`: purely combinational selection of addr/wdata/we/read by owner.
- FSM, `lock_cnt` and read-return registers stay in `data_mem_arbiter`.
- Integration test instantiates `Data_Memory` behind the arbiter.

## Test plan
1. **Single read.** Port 0 reads addr 3 (memory holds 16'h00A5).
   - `gnt0` high in cycle 1; `rvalid0` in cycle 2; `rdata0` = 16'h00A5; `gnt1` stays 0.
2. **Simultaneous writes after reset.** Both ports request: port 0 writes 16'h1111 to addr 1, port 1 writes 16'h2222 to addr 2.
   - Port 0 granted first, port 1 next cycle; memory[1] = 16'h1111, memory[2] = 16'h2222.
3. **Locked burst, forced handoff.** Port 1 holds `lock1` with 6 reads pending while port 0 requests; `LOCK_MAX` = 4.
   - Exactly 4 port-1 grants, then `gnt0` for one access, then port 1 resumes.
4. **Write then read.** Port 0 writes 16'hBEEF to addr 7, then reads addr 7.
   - `rdata0` = 16'hBEEF. Address 16'h000F also aliases to entry 7.
5. **Reset mid-access.** `rst_n` low during a port-1 write grant.
   - `gnt1`, `mem_write_en`, `rvalid` and `rdata` go 0 immediately; target word unchanged. After release, an idle cycle precedes any grant.
6. **Dropped request.** `req0` dropped in its grant cycle with `req1` low.
   - No memory enable that cycle, FSM returns to IDLE, no `rvalid0`.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port data memory arbiter.
package mem_arb_pkg;

  // Arbiter ownership states; encoding is fixed so gnt decodes directly.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_e;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  localparam int NUM_PORTS  = 2;
  localparam int CNT_W      = 4;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 16;

endpackage

// File: rtl/mem_arb_port_mux.sv
// Combinational selection of the owning port's access onto the memory pins.
module mem_arb_port_mux
  import mem_arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                              i_own_vld,
  input  logic                              i_own_sel,
  input  logic [NUM_PORTS-1:0]              i_req,
  input  logic [NUM_PORTS-1:0]              i_we,
  input  logic [NUM_PORTS-1:0][ADDR_W-1:0]  i_addr,
  input  logic [NUM_PORTS-1:0][DATA_W-1:0]  i_wdata,
  output logic [ADDR_W-1:0]                 o_addr,
  output logic [DATA_W-1:0]                 o_wdata,
  output logic                              o_we,
  output logic                              o_rd
);

  // Idle or dropped request drives an all-zero, no-enable access.
  always_comb begin
    o_addr  = '0;
    o_wdata = '0;
    o_we    = 1'b0;
    o_rd    = 1'b0;
    if (i_own_vld) begin
      o_addr  = i_addr[i_own_sel];
      o_wdata = i_wdata[i_own_sel];
      o_we    = i_req[i_own_sel] &  i_we[i_own_sel];
      o_rd    = i_req[i_own_sel] & ~i_we[i_own_sel];
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing a single-ported data memory between two
// requesters, with bounded lock bursts and registered per-port read return.
module data_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int LOCK_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic              lock0,
  input  logic              lock1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_access_addr,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write_en,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_read_data
);

  localparam logic [CNT_W-1:0] LOCK_LIM = CNT_W'(LOCK_MAX - 1);

  arb_state_e                           r_state, w_state_nxt;
  logic                                 r_last, w_last_nxt;
  logic [CNT_W-1:0]                     r_lock_cnt, w_cnt_nxt;

  logic [NUM_PORTS-1:0]                 w_req, w_we, w_lock, w_gnt;
  logic [NUM_PORTS-1:0][ADDR_W-1:0]     w_addr;
  logic [NUM_PORTS-1:0][DATA_W-1:0]     w_wdata;
  logic [NUM_PORTS-1:0]                 r_rvalid;
  logic [NUM_PORTS-1:0][DATA_W-1:0]     r_rdata;

  logic                                 w_own_vld, w_own_sel;
  logic                                 w_req_own, w_lock_own, w_req_oth;
  logic                                 w_mux_we, w_mux_rd;

  assign w_req   = {req1, req0};
  assign w_we    = {we1, we0};
  assign w_lock  = {lock1, lock0};
  assign w_addr  = {addr1, addr0};
  assign w_wdata = {wdata1, wdata0};

  assign w_gnt[PORT0] = (r_state == ST_OWN0);
  assign w_gnt[PORT1] = (r_state == ST_OWN1);
  assign w_own_vld    = |w_gnt;
  assign w_own_sel    = w_gnt[PORT1];

  assign w_req_own  = w_req[w_own_sel];
  assign w_lock_own = w_lock[w_own_sel];
  assign w_req_oth  = w_req[~w_own_sel];

  mem_arb_port_mux #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mux (
    .i_own_vld (w_own_vld),
    .i_own_sel (w_own_sel),
    .i_req     (w_req),
    .i_we      (w_we),
    .i_addr    (w_addr),
    .i_wdata   (w_wdata),
    .o_addr    (mem_access_addr),
    .o_wdata   (mem_write_data),
    .o_we      (w_mux_we),
    .o_rd      (w_mux_rd)
  );

  // Enables are also gated by rst_n so nothing strobes memory while reset is low.
  assign mem_write_en = w_mux_we & rst_n;
  assign mem_read     = w_mux_rd & rst_n;

  assign gnt0    = w_gnt[PORT0];
  assign gnt1    = w_gnt[PORT1];
  assign rvalid0 = r_rvalid[PORT0];
  assign rvalid1 = r_rvalid[PORT1];
  assign rdata0  = r_rdata[PORT0];
  assign rdata1  = r_rdata[PORT1];

  // Next-state: round-robin from idle, prioritized hold/handoff rules when owned.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_lock_cnt;
    w_last_nxt  = r_last;
    unique case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (req0 && req1)  w_state_nxt = r_last ? ST_OWN0 : ST_OWN1;
        else if (req0)     w_state_nxt = ST_OWN0;
        else if (req1)     w_state_nxt = ST_OWN1;
      end
      ST_OWN0, ST_OWN1: begin
        if (w_req_own) w_last_nxt = w_own_sel;
        if (w_req_own && w_lock_own && !w_req_oth) begin
          w_state_nxt = r_state;
        end else if (w_req_own && w_lock_own && (r_lock_cnt < LOCK_LIM)) begin
          w_state_nxt = r_state;
          w_cnt_nxt   = r_lock_cnt + 1'b1;
        end else if (w_req_oth) begin
          w_state_nxt = w_own_sel ? ST_OWN0 : ST_OWN1;
          w_cnt_nxt   = '0;
        end else if (w_req_own) begin
          w_state_nxt = r_state;
        end else begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // State, last-served port and lock counter; last=1 so port 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_last     <= PORT1;
      r_lock_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_last     <= w_last_nxt;
      r_lock_cnt <= w_cnt_nxt;
    end
  end

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_rret
    logic w_rd_done;
    assign w_rd_done = w_gnt[gi] & w_req[gi] & ~w_we[gi];

    // Capture read data at the edge ending a read and pulse rvalid for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_rvalid[gi] <= 1'b0;
        r_rdata[gi]  <= '0;
      end else begin
        r_rvalid[gi] <= w_rd_done;
        if (w_rd_done) r_rdata[gi] <= mem_read_data;
      end
    end
  end

endmodule
